ic_req_arb: RTL

//  Arbitrates the single ICache request port between the fetch stage and the

---
 rtl/ic_req_arb.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/ic_req_arb.sv
// ic_req_arb: arbitrates the single ICache request port between fetch and
// the prefetcher, tracks in-flight requests in an in-order ID FIFO and routes
// each ICache response back to the requester that issued it. A flush clears
// the valid bit of every in-flight entry so their responses are dropped.
//
// Build option: define IC_ARB_RR_EN for round-robin between fetch and
// prefetch; without it fetch has fixed priority over prefetch.

`ifndef AddrWidth
`define AddrWidth 32
`endif
`ifndef InstWidth
`define InstWidth 32
`endif

module ic_req_arb #(
  parameter int unsigned ADDR  = `AddrWidth,
  parameter int unsigned INST  = `InstWidth,
  parameter int unsigned OUTST = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  // fetch request side
  input  logic            fetch_e_,
  input  logic [ADDR-1:0] fetch_pc,
  output logic            fetch_gnt_,
  // prefetch request side
  input  logic            pf_e_,
  input  logic [ADDR-1:0] pf_pc,
  output logic            pf_gnt_,
  // ICache request
  output logic            ic_req_e_,
  output logic [ADDR-1:0] ic_req_pc,
  // ICache response
  input  logic            ic_e_,
  input  logic [ADDR-1:0] ic_pc,
  input  logic [INST-1:0] ic_inst,
  // routed responses
  output logic            fetch_rsp_e_,
  output logic [ADDR-1:0] fetch_rsp_pc,
  output logic [INST-1:0] fetch_rsp_inst,
  output logic            pf_done_e_,
  // status
  output logic            busy,
  output logic            err
);

  localparam int unsigned PW = (OUTST > 1) ? $clog2(OUTST) : 1;
  localparam int unsigned CW = $clog2(OUTST) + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(OUTST);

  // ID FIFO state: one valid bit and one requester id bit per slot
  logic [OUTST-1:0] vld_q, vld_d;
  logic [OUTST-1:0] id_q, id_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  // registered outputs
  logic             ic_req_e_q, ic_req_e_d;
  logic [ADDR-1:0]  ic_req_pc_q, ic_req_pc_d;
  logic             fetch_rsp_e_q, fetch_rsp_e_d;
  logic [ADDR-1:0]  fetch_rsp_pc_q, fetch_rsp_pc_d;
  logic [INST-1:0]  fetch_rsp_inst_q, fetch_rsp_inst_d;
  logic             pf_done_e_q, pf_done_e_d;
  logic             busy_q, busy_d;
  logic             err_q, err_d;

  // arbitration / handshake terms
  logic fetch_req;
  logic pf_req;
  logic pop;
  logic can_grant;
  logic gnt_f;
  logic gnt_p;
  logic push;
  logic pop_vld;
  logic pop_id;
  logic deliver;

`ifdef IC_ARB_RR_EN
  logic both_req;
  logic pf_turn_q, pf_turn_d;
`endif

  // Grant decision: combinational, at most one grant, blocked by flush or full FIFO
  always_comb begin
    fetch_req = ~fetch_e_;
    pf_req    = ~pf_e_;
    pop       = ~ic_e_ & (cnt_q != '0);
    // a popping response frees a slot in the same cycle
    can_grant = ~reset & ~flush & ((cnt_q < FULL_CNT) | pop);
`ifdef IC_ARB_RR_EN
    both_req  = fetch_req & pf_req;
    gnt_f     = can_grant & fetch_req & ~(both_req & pf_turn_q);
    pf_turn_d = pf_turn_q ^ (both_req & can_grant);
`else
    gnt_f     = can_grant & fetch_req;
`endif
    gnt_p     = can_grant & pf_req & ~gnt_f;
    push      = gnt_f | gnt_p;
  end

  assign fetch_gnt_ = ~gnt_f;
  assign pf_gnt_    = ~gnt_p;

  // ID FIFO update: pop, then flush invalidation, then push of the new grant
  always_comb begin
    vld_d    = vld_q;
    id_d     = id_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    pop_vld  = vld_q[rd_ptr_q];
    pop_id   = id_q[rd_ptr_q];
    if (pop) begin
      vld_d[rd_ptr_q] = 1'b0;
      rd_ptr_d        = rd_ptr_q + PW'(1);
    end
    // pointers are kept so in-order responses still line up with their slots
    if (flush) begin
      vld_d = '0;
    end
    // when full, a push lands in the slot the pop just freed
    if (push) begin
      vld_d[wr_ptr_q] = 1'b1;
      id_d[wr_ptr_q]  = gnt_p;
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end
    cnt_d = cnt_q + CW'(push) - CW'(pop);
  end

  // Next values of the request, response and status outputs
  always_comb begin
    ic_req_e_d       = ~push;
    ic_req_pc_d      = ic_req_pc_q;
    fetch_rsp_pc_d   = fetch_rsp_pc_q;
    fetch_rsp_inst_d = fetch_rsp_inst_q;
    if (gnt_f) begin
      ic_req_pc_d = fetch_pc;
    end else if (gnt_p) begin
      ic_req_pc_d = pf_pc;
    end
    // stale (flushed) entries and responses in a flush cycle are swallowed
    deliver       = pop & pop_vld & ~flush;
    fetch_rsp_e_d = ~(deliver & ~pop_id);
    pf_done_e_d   = ~(deliver & pop_id);
    if (deliver & ~pop_id) begin
      fetch_rsp_pc_d   = ic_pc;
      fetch_rsp_inst_d = ic_inst;
    end
    err_d  = err_q | (~ic_e_ & (cnt_q == '0));
    busy_d = |vld_d;
  end

  // State registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_q            <= '0;
      id_q             <= '0;
      wr_ptr_q         <= '0;
      rd_ptr_q         <= '0;
      cnt_q            <= '0;
      ic_req_e_q       <= 1'b1;
      ic_req_pc_q      <= '0;
      fetch_rsp_e_q    <= 1'b1;
      fetch_rsp_pc_q   <= '0;
      fetch_rsp_inst_q <= '0;
      pf_done_e_q      <= 1'b1;
      busy_q           <= 1'b0;
      err_q            <= 1'b0;
    end else begin
      vld_q            <= vld_d;
      id_q             <= id_d;
      wr_ptr_q         <= wr_ptr_d;
      rd_ptr_q         <= rd_ptr_d;
      cnt_q            <= cnt_d;
      ic_req_e_q       <= ic_req_e_d;
      ic_req_pc_q      <= ic_req_pc_d;
      fetch_rsp_e_q    <= fetch_rsp_e_d;
      fetch_rsp_pc_q   <= fetch_rsp_pc_d;
      fetch_rsp_inst_q <= fetch_rsp_inst_d;
      pf_done_e_q      <= pf_done_e_d;
      busy_q           <= busy_d;
      err_q            <= err_d;
    end
  end

`ifdef IC_ARB_RR_EN
  // Round-robin turn bit; reset favours fetch
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pf_turn_q <= 1'b0;
    end else begin
      pf_turn_q <= pf_turn_d;
    end
  end
`endif

  assign ic_req_e_      = ic_req_e_q;
  assign ic_req_pc      = ic_req_pc_q;
  assign fetch_rsp_e_   = fetch_rsp_e_q;
  assign fetch_rsp_pc   = fetch_rsp_pc_q;
  assign fetch_rsp_inst = fetch_rsp_inst_q;
  assign pf_done_e_     = pf_done_e_q;
  assign busy           = busy_q;
  assign err            = err_q;

endmodule
